// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the QoS grant scheduler.
package stream_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

  // Width needed to hold an age counter that saturates at age_limit.
  function automatic int age_width(input int age_limit);
    return (age_limit < 1) ? 1 : $clog2(age_limit + 1);
  endfunction

endpackage

// File: rtl/qos_prio_select.sv
// Combinational winner pick: starving requesters first (round-robin), else
// highest QoS with round-robin tie-break starting after rr_ptr.
module qos_prio_select
  import stream_arbiter_pkg::*;
#(
  parameter int STREAM_COUNT = 2,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic [STREAM_COUNT-1:0] req,
  input  logic [T_QOS__WIDTH-1:0] qos [STREAM_COUNT-1:0],
  input  logic [STREAM_COUNT-1:0] starving,
  input  logic [T_ID___WIDTH-1:0] rr_ptr,
  output logic [T_ID___WIDTH-1:0] winner_id,
  output logic                    found
);

  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

  logic                    any_starving;
  logic                    cand;
  logic [T_ID___WIDTH-1:0] idx;
  logic [T_QOS__WIDTH-1:0] best_qos;

  // Walking in round-robin order and only replacing on strictly higher QoS
  // makes the first candidate in that order win every tie.
  always_comb begin
    any_starving = |(req & starving);
    found        = 1'b0;
    winner_id    = '0;
    best_qos     = '0;
    cand         = 1'b0;
    idx          = rr_ptr;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      if (idx == LAST_ID) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
      cand = any_starving ? (req[idx] && starving[idx]) : req[idx];
      if (cand && (!found || (!any_starving && (qos[idx] > best_qos)))) begin
        found     = 1'b1;
        winner_id = idx;
        best_qos  = qos[idx];
      end
    end
  end

endmodule

// File: rtl/qos_grant_scheduler.sv
// Packet-level grant scheduler: picks one stream per packet by QoS with
// anti-starvation ageing, and holds the grant until the last beat is accepted.
module qos_grant_scheduler
  import stream_arbiter_pkg::*;
#(
  parameter int STREAM_COUNT = 2,
  parameter int T_QOS__WIDTH = 4,
  parameter int AGE_LIMIT    = 15,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [STREAM_COUNT-1:0] req_i,
  input  logic [T_QOS__WIDTH-1:0] qos_i [STREAM_COUNT-1:0],
  input  logic                    xfer_i,
  input  logic                    last_i,
  output logic [STREAM_COUNT-1:0] grant_o,
  output logic [T_ID___WIDTH-1:0] grant_id_o,
  output logic                    grant_valid_o
);

  localparam int                      AGE_W   = age_width(AGE_LIMIT);
  localparam logic [AGE_W-1:0]        AGE_MAX = AGE_W'(AGE_LIMIT);
  localparam logic [T_ID___WIDTH-1:0] RR_INIT = T_ID___WIDTH'(STREAM_COUNT - 1);

  sched_state_e            state_reg, state_next;
  logic [STREAM_COUNT-1:0] grant_reg, grant_next;
  logic [T_ID___WIDTH-1:0] grant_id_reg, grant_id_next;
  logic [T_ID___WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [AGE_W-1:0]        age_reg [STREAM_COUNT];

  logic [STREAM_COUNT-1:0] starving;
  logic [STREAM_COUNT-1:0] grant_now;
  logic [T_ID___WIDTH-1:0] winner_id;
  logic                    winner_found;

  genvar gi;
  generate
    for (gi = 0; gi < STREAM_COUNT; gi++) begin : g_stream
      assign starving[gi]  = (age_reg[gi] == AGE_MAX);
      assign grant_now[gi] = (state_reg == IDLE) && winner_found &&
                             (winner_id == T_ID___WIDTH'(gi));

      // Age only accumulates while genuinely waiting; holding the grant keeps it at 0.
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
          age_reg[gi] <= '0;
        end else if (!req_i[gi] || grant_reg[gi] || grant_now[gi]) begin
          age_reg[gi] <= '0;
        end else if (age_reg[gi] != AGE_MAX) begin
          age_reg[gi] <= age_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  qos_prio_select #(
    .STREAM_COUNT (STREAM_COUNT),
    .T_QOS__WIDTH (T_QOS__WIDTH),
    .T_ID___WIDTH (T_ID___WIDTH)
  ) u_prio_select (
    .req       (req_i),
    .qos       (qos_i),
    .starving  (starving),
    .rr_ptr    (rr_ptr_reg),
    .winner_id (winner_id),
    .found     (winner_found)
  );

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (winner_found) begin
          state_next    = LOCK;
          grant_next    = grant_now;
          grant_id_next = winner_id;
          rr_ptr_next   = winner_id;
        end
      end
      LOCK: begin
        if (xfer_i && last_i) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      rr_ptr_reg   <= RR_INIT;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

  assign grant_o       = grant_reg;
  assign grant_id_o    = grant_id_reg;
  assign grant_valid_o = (state_reg == LOCK);

endmodule

// File: doc/qos_grant_scheduler.md
QOS_GRANT_SCHEDULER -- requirements
Module: qos_grant_scheduler

Interface
REQ-001 The block SHALL have parameter STREAM_COUNT, default 2, meaning the number of requesting streams (≥2).
REQ-002 The block SHALL have parameter T_QOS__WIDTH, default 4, meaning the width of the per-stream QoS value.
REQ-003 The block SHALL have parameter AGE_LIMIT, default 15, meaning the count of waiting cycles after which a requester is starving.
REQ-004 The block SHALL have parameter T_ID___WIDTH, default $clog2(STREAM_COUNT), meaning the grant index width.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port req_i, input, STREAM_COUNT bits, per-stream valid/request.
REQ-008 The block SHALL have port qos_i, input, unpacked array [STREAM_COUNT-1:0] of T_QOS__WIDTH bits, per-stream priority.
REQ-009 The block SHALL have port xfer_i, input, 1 bit, meaning a beat is accepted on the shared output (valid && ready).
REQ-010 The block SHALL have port last_i, input, 1 bit, meaning the accepted beat is the packet's last.
REQ-011 The block SHALL have port grant_o, output, STREAM_COUNT bits, one-hot or zero grant vector.
REQ-012 The block SHALL have port grant_id_o, output, T_ID___WIDTH bits, index of the granted stream.
REQ-013 The block SHALL have port grant_valid_o, output, 1 bit, high while a grant is held.

Function
REQ-014 The FSM SHALL have two states, IDLE and LOCK; in IDLE grant_o=0 and grant_valid_o=0.
REQ-015 In IDLE with any req_i bit high at a clock edge, the block SHALL register the winner and enter LOCK; grant appears one cycle after the request is sampled.
REQ-016 In LOCK, grant_o, grant_id_o and grant_valid_o SHALL remain constant regardless of req_i or qos_i changes.
REQ-017 In LOCK, xfer_i && last_i SHALL return the FSM to IDLE at that edge; xfer_i without last_i, or last_i without xfer_i, SHALL NOT release.
REQ-018 The winner SHALL be selected from the following: any starving requester beats all non-starving ones; otherwise highest qos_i wins; ties SHALL break round-robin starting at the index after the last granted id.
REQ-019 Among multiple starving requesters, the winner SHALL be chosen round-robin, ignoring QoS.
REQ-020 Each stream SHALL own an age counter of width $clog2(AGE_LIMIT+1): it SHALL increment every cycle req_i is high and the stream is not granted, and SHALL saturate at AGE_LIMIT.
REQ-021 The age counter SHALL clear to 0 on the edge the stream is granted, and SHALL clear while its req_i is low.
REQ-022 A stream SHALL be starving when its age equals AGE_LIMIT.
REQ-023 The round-robin pointer SHALL update to the granted id on every IDLE->LOCK transition and SHALL wrap from STREAM_COUNT-1 to 0.
REQ-024 A zero-length release is not possible: minimum LOCK occupancy SHALL be one cycle (a single-beat packet with xfer_i && last_i in the first LOCK cycle).
REQ-025 Between consecutive packets the block SHALL insert exactly one IDLE cycle.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously set FSM=IDLE, grant_o=0, grant_id_o=0, grant_valid_o=0, all age counters=0 and the round-robin pointer=STREAM_COUNT-1, so that stream 0 wins the first tie.
REQ-027 Reset asserted mid-packet SHALL drop the grant immediately, without waiting for last_i.
REQ-028 Reset release SHALL be synchronised by the integrator; the block SHALL sample no requests in the release cycle beyond normal edge behaviour.

Structure
REQ-029 The package stream_arbiter_pkg SHALL hold the FSM state enum (IDLE, LOCK) and the age-width helper function.
REQ-030 Winner selection SHALL be one combinational sub-module, qos_prio_select (inputs req, qos, starving, rr pointer; output winner id and a found flag), instantiated once.
REQ-031 All registers SHALL live in qos_grant_scheduler.

Verification
REQ-032 Scenario: N=2, req=2'b11, qos={3,5} (stream1=5) -> grant_o=2'b10 and grant_id_o=1 one cycle later, held through 4 beats until xfer_i&&last_i, then one IDLE cycle.
REQ-033 Scenario: equal qos=4 on both streams, requests held continuously -> grants alternate 0,1,0,1 across four packets.
REQ-034 Scenario: stream0 qos=1 requesting, stream1 qos=9 sends back-to-back 20-beat packets -> stream0 starves at 15 cycles and is granted at the next IDLE ahead of stream1.
REQ-035 Scenario: in LOCK, toggle req_i and change qos_i -> grant unchanged; last_i without xfer_i -> no release.
REQ-036 Scenario: rst_n low during beat 2 of a packet -> grant_valid_o=0 asynchronously, ages 0, first post-reset tie grants stream 0.
